// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences a single-port unified RAM shared by instruction fetch (IF) and
// load/store (MEM). One transaction at a time, MEM priority, IF forced in after STARVE_MAX MEM grants.
module mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(RD_LAT - 1);
    localparam logic [3:0] STARVE_SAT = 4'(STARVE_MAX);

    state_t            r_state;
    logic              r_owner_if;
    logic              r_en;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        r_starve;
    logic              w_any_req;
    logic              w_grant_if;

    assign w_any_req = if_req | mem_req;

    // MEM wins unless IF has already been passed over STARVE_MAX times in a row.
    always_comb begin
        if (mem_req && !(if_req && (r_starve == STARVE_SAT))) begin
            w_grant_if = 1'b0;
        end else begin
            w_grant_if = if_req;
        end
    end

    // Transaction sequencer: IDLE -> ISSUE -> (WAIT) -> RESP, all outputs registered.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            r_state     <= IDLE;
            r_owner_if  <= 1'b0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_starve    <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner_if <= w_grant_if;
                        r_en       <= 1'b1;
                        r_state    <= ISSUE;
                        if (w_grant_if) begin
                            r_we     <= 1'b0;
                            r_addr   <= if_addr;
                            r_wdata  <= 32'd0;
                            r_starve <= 4'd0;
                        end else begin
                            r_we    <= mem_we;
                            r_addr  <= mem_addr;
                            r_wdata <= mem_wdata;
                            if (if_req && (r_starve != STARVE_SAT)) begin
                                r_starve <= r_starve + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    r_en <= 1'b0;
                    if (r_we) begin
                        r_if_ready  <= r_owner_if;
                        r_mem_ready <= ~r_owner_if;
                        r_state     <= RESP;
                    end else begin
                        r_wait_cnt <= WAIT_INIT;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter hits zero in exactly the cycle ram_rdata is valid.
                    if (r_wait_cnt == 4'd0) begin
                        if (r_owner_if) begin
                            r_if_rdata <= ram_rdata;
                        end else begin
                            r_mem_rdata <= ram_rdata;
                        end
                        r_if_ready  <= r_owner_if;
                        r_mem_ready <= ~r_owner_if;
                        r_state     <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_en        <= 1'b0;
                    r_if_ready  <= 1'b0;
                    r_mem_ready <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign ram_en    = r_en;
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = r_mem_ready;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = mem_req & ~r_mem_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized requesters checked every cycle against a transaction-timing
// model, plus directed scenarios and RD_LAT=1/4 latency builds.
module tb_mem_arbiter;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 3;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } mreq_t;

    logic Clock = 1'b0;
    logic Resetn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    logic        if_req, mem_req, mem_we;
    logic [4:0]  if_addr, mem_addr;
    logic [31:0] mem_wdata, if_rdata, mem_rdata;
    logic        if_ready, mem_ready, stall_if, stall_mem;

    logic        ram_en_a [3];
    logic        ram_we_a [3];
    logic [4:0]  ram_addr_a [3];
    logic [31:0] ram_wdata_a [3];
    logic [31:0] ram_rdata_a [3];

    logic        l_if_req [1:2];
    logic [4:0]  l_if_addr;
    logic [31:0] l_if_rdata [1:2];
    logic [31:0] l_mem_rdata [1:2];
    logic        l_if_ready [1:2];
    logic        l_mem_ready [1:2];
    logic        l_stall_if [1:2];
    logic        l_stall_mem [1:2];

    mem_arbiter #(.ADDR_W(5), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en_a[0]), .ram_we(ram_we_a[0]), .ram_addr(ram_addr_a[0]),
        .ram_wdata(ram_wdata_a[0]), .ram_rdata(ram_rdata_a[0])
    );

    mem_arbiter #(.ADDR_W(5), .RD_LAT(1), .STARVE_MAX(SMAX)) dut_lat1 (
        .Clock(Clock), .Resetn(Resetn),
        .if_req(l_if_req[1]), .if_addr(l_if_addr), .if_rdata(l_if_rdata[1]), .if_ready(l_if_ready[1]),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(5'd0), .mem_wdata(32'd0),
        .mem_rdata(l_mem_rdata[1]), .mem_ready(l_mem_ready[1]), .stall_if(l_stall_if[1]), .stall_mem(l_stall_mem[1]),
        .ram_en(ram_en_a[1]), .ram_we(ram_we_a[1]), .ram_addr(ram_addr_a[1]),
        .ram_wdata(ram_wdata_a[1]), .ram_rdata(ram_rdata_a[1])
    );

    mem_arbiter #(.ADDR_W(5), .RD_LAT(4), .STARVE_MAX(SMAX)) dut_lat4 (
        .Clock(Clock), .Resetn(Resetn),
        .if_req(l_if_req[2]), .if_addr(l_if_addr), .if_rdata(l_if_rdata[2]), .if_ready(l_if_ready[2]),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr(5'd0), .mem_wdata(32'd0),
        .mem_rdata(l_mem_rdata[2]), .mem_ready(l_mem_ready[2]), .stall_if(l_stall_if[2]), .stall_mem(l_stall_mem[2]),
        .ram_en(ram_en_a[2]), .ram_we(ram_we_a[2]), .ram_addr(ram_addr_a[2]),
        .ram_wdata(ram_wdata_a[2]), .ram_rdata(ram_rdata_a[2])
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h8C22_0004;
        return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? RD_LAT : ((k == 1) ? 1 : 4);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endfunction

    // RAM models: read data is valid only in the cycle RD_LAT after ram_en, garbage otherwise.
    logic [31:0] ram [3][32];
    logic [31:0] pd [3][4];
    logic        pv [3][4];

    always @(posedge Clock) begin
        for (int k = 0; k < 3; k++) begin
            if (cyc == 0) begin
                for (int i = 0; i < 32; i++) ram[k][i] <= init_word(i);
            end else if (ram_en_a[k] && ram_we_a[k]) begin
                ram[k][ram_addr_a[k]] <= ram_wdata_a[k];
            end
            pv[k][0] <= (cyc != 0) && ram_en_a[k] && !ram_we_a[k];
            pd[k][0] <= ram[k][ram_addr_a[k]];
            for (int j = 1; j < 4; j++) begin
                pv[k][j] <= (cyc != 0) && pv[k][j-1];
                pd[k][j] <= pd[k][j-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ram_rdata_a[k] = (pv[k][lat_of(k)-1] === 1'b1) ? pd[k][lat_of(k)-1] : 32'hBAD0_BAD0;
        end
    end

    // Requesters: pop queued requests, hold each until its ready pulse.
    logic [4:0] if_q [$];
    mreq_t      mem_q [$];
    int         gap_pct = 0;
    int         if_t0 = 0;
    int         mem_t0 = 0;

    initial begin : driver
        logic  if_done, mem_done;
        mreq_t m;
        if_req = 1'b0; if_addr = 5'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 5'd0; mem_wdata = 32'd0;
        forever begin
            @(negedge Clock);
            if_done  = if_ready;
            mem_done = mem_ready;
            @(posedge Clock);
            #1;
            if (Resetn) begin
                if_req  = 1'b0;
                mem_req = 1'b0;
            end else begin
                if (if_req && if_done) if_req = 1'b0;
                if (mem_req && mem_done) mem_req = 1'b0;
                if (!if_req && if_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    if_addr = if_q.pop_front();
                    if_req  = 1'b1;
                    if_t0   = cyc;
                end
                if (!mem_req && mem_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    m         = mem_q.pop_front();
                    mem_we    = m.we;
                    mem_addr  = m.addr;
                    mem_wdata = m.wdata;
                    mem_req   = 1'b1;
                    mem_t0    = cyc;
                end
            end
        end
    end

    // Event logs for directed checks.
    int          ev_en_cyc [$];
    logic [4:0]  ev_en_addr [$];
    logic        ev_en_we [$];
    logic [31:0] ev_en_wdata [$];
    int          ev_ifr_cyc [$];
    logic [31:0] ev_ifr_data [$];
    int          ev_memr_cyc [$];
    int          stall_if_cnt = 0;

    // Reference model: a granted transaction fixes its ram_en and ready cycles by arithmetic.
    initial begin : model
        int          free_cyc, en_cyc, rdy_cyc, starve;
        logic        t_if, t_we, e_en, e_ifr, e_memr;
        logic [4:0]  t_addr;
        logic [31:0] t_wdata, e_if_rdata, e_mem_rdata;
        logic [31:0] m_mem [32];
        for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);
        free_cyc = 0; en_cyc = -100; rdy_cyc = -100; starve = 0;
        t_if = 1'b0; t_we = 1'b0; t_addr = 5'd0; t_wdata = 32'd0;
        e_if_rdata = 32'd0; e_mem_rdata = 32'd0;
        forever begin
            @(negedge Clock);
            if (Resetn) begin
                free_cyc = 0; en_cyc = -100; rdy_cyc = -100; starve = 0;
                e_if_rdata = 32'd0; e_mem_rdata = 32'd0;
                e_en = 1'b0; e_ifr = 1'b0; e_memr = 1'b0;
                chk1("rst_ram_we", ram_we_a[0], 1'b0);
                chk("rst_ram_addr", 32'(ram_addr_a[0]), 32'd0);
                chk("rst_ram_wdata", ram_wdata_a[0], 32'd0);
            end else begin
                if (cyc >= free_cyc && (if_req || mem_req)) begin
                    if (mem_req && !(if_req && starve == SMAX)) begin
                        t_if = 1'b0; t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
                        if (if_req && starve < SMAX) starve++;
                    end else begin
                        t_if = 1'b1; t_we = 1'b0; t_addr = if_addr; t_wdata = 32'd0;
                        starve = 0;
                    end
                    en_cyc   = cyc + 1;
                    rdy_cyc  = cyc + (t_we ? 2 : RD_LAT + 2);
                    free_cyc = rdy_cyc + 1;
                end
                e_en   = (cyc == en_cyc);
                e_ifr  = (cyc == rdy_cyc) && t_if;
                e_memr = (cyc == rdy_cyc) && !t_if;
                if (cyc == rdy_cyc && !t_we) begin
                    if (t_if) e_if_rdata = m_mem[t_addr];
                    else      e_mem_rdata = m_mem[t_addr];
                end
            end
            chk1("ram_en", ram_en_a[0], e_en);
            if (e_en) begin
                chk1("ram_we", ram_we_a[0], t_we);
                chk("ram_addr", 32'(ram_addr_a[0]), 32'(t_addr));
                if (t_we) chk("ram_wdata", ram_wdata_a[0], t_wdata);
            end
            chk1("if_ready", if_ready, e_ifr);
            chk1("mem_ready", mem_ready, e_memr);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("mem_rdata", mem_rdata, e_mem_rdata);
            chk1("stall_if", stall_if, if_req & ~e_ifr);
            chk1("stall_mem", stall_mem, mem_req & ~e_memr);
            if (!Resetn && e_en && t_we) m_mem[t_addr] = t_wdata;
            if (ram_en_a[0]) begin
                ev_en_cyc.push_back(cyc);
                ev_en_addr.push_back(ram_addr_a[0]);
                ev_en_we.push_back(ram_we_a[0]);
                ev_en_wdata.push_back(ram_wdata_a[0]);
            end
            if (if_ready) begin
                ev_ifr_cyc.push_back(cyc);
                ev_ifr_data.push_back(if_rdata);
            end
            if (mem_ready) ev_memr_cyc.push_back(cyc);
            if (stall_if) stall_if_cnt++;
        end
    end

    task automatic clear_logs();
        ev_en_cyc.delete(); ev_en_addr.delete(); ev_en_we.delete(); ev_en_wdata.delete();
        ev_ifr_cyc.delete(); ev_ifr_data.delete(); ev_memr_cyc.delete();
        stall_if_cnt = 0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        @(negedge Clock);
        while (n < max && !(if_q.size() == 0 && mem_q.size() == 0 && !if_req && !mem_req)) begin
            @(negedge Clock);
            n++;
        end
        chk("idle_timeout", 32'(n < max), 32'd1);
        repeat (2) @(negedge Clock);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [4:0]  exp_order [6];
        mreq_t       m;
        int          t0;
        int          rdy [1:2];
        int          en_cnt [1:2];
        int          st_cnt [1:2];
        logic [31:0] dat [1:2];
        logic        done [1:2];
        exp_order = '{5'd7, 5'd7, 5'd7, 5'd1, 5'd7, 5'd7};
        l_if_req[1] = 1'b0; l_if_req[2] = 1'b0; l_if_addr = 5'd0;
        Resetn = 1'b0;
        #1 Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        chk1("rst_ram_en", ram_en_a[0], 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        @(posedge Clock); #2 Resetn = 1'b0;

        // IF read of word 5.
        clear_logs();
        if_q.push_back(5'd5);
        wait_idle(40);
        chk("rd_en_cycle", ev_en_cyc[0] - if_t0, 1);
        chk("rd_en_addr", 32'(ev_en_addr[0]), 32'd5);
        chk1("rd_en_we", ev_en_we[0], 1'b0);
        chk("rd_ready_cycle", ev_ifr_cyc[0] - if_t0, 4);
        chk("rd_rdata", ev_ifr_data[0], 32'h8C22_0004);
        chk("rd_stall_cycles", stall_if_cnt, 4);
        chk("rd_en_count", ev_en_cyc.size(), 1);

        // Store to word 3.
        clear_logs();
        m.we = 1'b1; m.addr = 5'd3; m.wdata = 32'hDEAD_BEEF;
        mem_q.push_back(m);
        wait_idle(40);
        chk("st_en_cycle", ev_en_cyc[0] - mem_t0, 1);
        chk("st_en_addr", 32'(ev_en_addr[0]), 32'd3);
        chk1("st_en_we", ev_en_we[0], 1'b1);
        chk("st_en_wdata", ev_en_wdata[0], 32'hDEAD_BEEF);
        chk("st_ready_cycle", ev_memr_cyc[0] - mem_t0, 2);
        chk("st_mem_rdata_kept", mem_rdata, 32'd0);

        // Simultaneous requests: MEM load first, IF follows after MEM's RESP.
        clear_logs();
        m.we = 1'b0; m.addr = 5'd7; m.wdata = 32'd0;
        if_q.push_back(5'd9);
        mem_q.push_back(m);
        wait_idle(60);
        chk("sim_first_addr", 32'(ev_en_addr[0]), 32'd7);
        chk("sim_second_addr", 32'(ev_en_addr[1]), 32'd9);
        chk("sim_mem_ready", ev_memr_cyc[0] - mem_t0, 4);
        chk("sim_if_en", ev_en_cyc[1] - if_t0, 6);
        chk("sim_if_ready", ev_ifr_cyc[0] - if_t0, 9);
        chk("sim_en_count", ev_en_cyc.size(), 2);
        chk("sim_mem_rdata", mem_rdata, init_word(7));

        // Starvation: IF held while MEM issues five loads back to back.
        clear_logs();
        if_q.push_back(5'd1); if_q.push_back(5'd1);
        for (int i = 0; i < 5; i++) mem_q.push_back(m);
        wait_idle(200);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), 32'(ev_en_addr[i]), 32'(exp_order[i]));

        // Reset in the middle of a read.
        clear_logs();
        if_q.push_back(5'd4);
        for (int n = 0; n < 20 && ev_en_cyc.size() == 0; n++) @(negedge Clock);
        chk("mid_rst_en_seen", ev_en_cyc.size(), 1);
        @(posedge Clock); #2 Resetn = 1'b1;
        #1;
        chk1("mid_rst_ram_en", ram_en_a[0], 1'b0);
        chk1("mid_rst_if_ready", if_ready, 1'b0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        chk("mid_rst_mem_rdata", mem_rdata, 32'd0);
        chk("mid_rst_ram_addr", 32'(ram_addr_a[0]), 32'd0);
        repeat (2) @(posedge Clock);
        #2 Resetn = 1'b0;
        repeat (8) @(negedge Clock);
        chk("mid_rst_no_ready", ev_ifr_cyc.size(), 0);
        clear_logs();
        if_q.push_back(5'd5);
        wait_idle(40);
        chk("post_rst_ready_cycle", ev_ifr_cyc[0] - if_t0, 4);
        chk("post_rst_rdata", ev_ifr_data[0], 32'h8C22_0004);

        // RD_LAT=1 and RD_LAT=4 builds.
        @(posedge Clock); #1;
        t0 = cyc;
        l_if_addr = 5'd9;
        for (int k = 1; k <= 2; k++) begin
            l_if_req[k] = 1'b1; rdy[k] = -1; en_cnt[k] = 0; st_cnt[k] = 0; dat[k] = 32'd0; done[k] = 1'b0;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge Clock);
            for (int k = 1; k <= 2; k++) begin
                if (ram_en_a[k]) en_cnt[k]++;
                if (l_stall_if[k]) st_cnt[k]++;
                if (l_if_ready[k]) begin
                    rdy[k] = cyc - t0; dat[k] = l_if_rdata[k]; done[k] = 1'b1;
                end
            end
            @(posedge Clock); #1;
            for (int k = 1; k <= 2; k++) if (done[k]) l_if_req[k] = 1'b0;
        end
        chk("lat1_ready_cycle", rdy[1], 3);
        chk("lat4_ready_cycle", rdy[2], 6);
        chk("lat1_rdata", dat[1], init_word(9));
        chk("lat4_rdata", dat[2], init_word(9));
        chk("lat1_en_count", en_cnt[1], 1);
        chk("lat4_en_count", en_cnt[2], 1);
        chk("lat1_stall_cycles", st_cnt[1], 3);
        chk("lat4_stall_cycles", st_cnt[2], 6);
        for (int k = 1; k <= 2; k++) begin
            chk1("lat_mem_ready", l_mem_ready[k], 1'b0);
            chk1("lat_stall_mem", l_stall_mem[k], 1'b0);
            chk("lat_mem_rdata", l_mem_rdata[k], 32'd0);
        end

        // Randomized mixed traffic against the model.
        clear_logs();
        gap_pct = 30;
        for (int i = 0; i < 80; i++) begin
            if_q.push_back(5'($urandom));
            m.we = 1'($urandom); m.addr = 5'($urandom); m.wdata = $urandom;
            mem_q.push_back(m);
        end
        wait_idle(5000);
        chk("rand_grant_count", ev_en_cyc.size(), 160);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences one single-port unified instruction/data RAM that is shared by the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Arbitrates between the two stages, issues one RAM transaction at a time, and waits a fixed RAM read latency.
- Returns data to the requester with a one-cycle ready pulse.
- Produces per-stage stall signals that the pipeline stall logic ORs into its existing stall.

Parameters:
- ADDR_W, 5, RAM word-address width.
- RD_LAT, 2, cycles from the ram_en cycle to the cycle in which ram_rdata is valid (1..15).
- STARVE_MAX, 3, consecutive MEM grants while if_req is pending before IF is forced a grant (1..15).

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous reset, ACTIVE-HIGH (1 = reset), despite the name.
- if_req  in  1  IF fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  32  fetched instruction; valid while if_ready=1, held afterwards.
- if_ready  out  1  one-cycle completion pulse to IF.
- mem_req  in  1  MEM access request; held with mem_we/addr/wdata until mem_ready.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_ready=1, held afterwards.
- mem_ready  out  1  one-cycle completion pulse to MEM.
- stall_if  out  1  if_req & ~if_ready.
- stall_mem  out  1  mem_req & ~mem_ready.
- ram_en  out  1  RAM access strobe, exactly one cycle per transaction.
- ram_we  out  1  RAM write enable, qualified by ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after the ram_en cycle.

Behaviour:
- Reset (asynchronous, while Resetn=1):
  - State goes to IDLE.
  - ram_en, ram_we, if_ready, mem_ready = 0.
  - ram_addr, ram_wdata, if_rdata, mem_rdata = 0.
  - Wait counter and starve counter = 0.
  - Any in-flight transaction is dropped and no ready is ever issued for it.
- State machine: IDLE -> ISSUE -> WAIT (reads only) -> RESP -> IDLE.
- IDLE:
  - Arbitration happens only in this state.
  - If any request is present, register owner, we, addr and wdata into ram_* and go to ISSUE.
  - If no request is present, stay in IDLE.
- ISSUE:
  - ram_en=1 for this cycle only.
  - Write: go to RESP.
  - Read: load the wait counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0 (the cycle that is RD_LAT cycles after ISSUE), capture ram_rdata into the owner's rdata register at the clock edge and go to RESP.
- RESP:
  - Owner's ready=1 for exactly one cycle; then go to IDLE.
  - A request still asserted during RESP is treated as the completed one and is not re-granted.
- Latency, counting the request cycle as 0:
  - Read: ready in cycle RD_LAT+2.
  - Write: ready in cycle 2.
  - Minimum spacing between ram_en pulses: read RD_LAT+3 cycles; write 3 cycles.
- Arbitration:
  - MEM has priority, because it belongs to the older instruction.
  - Starve counter: increments, saturating at STARVE_MAX, on each MEM grant made while if_req=1.
  - When starve counter = STARVE_MAX and both stages request, IF is granted.
  - Any IF grant clears the starve counter.
  - An IF grant made with mem_req=0 also clears it.
- Requests that drop without completing are a protocol violation and have undefined results.
- Changing addr/data while req is held is also a protocol violation with undefined results.
- rdata registers change only on their own owner's capture.
- Store completion leaves mem_rdata unchanged.
- stall_* are combinational from the req inputs and the registered ready outputs.

Test Plan:
- Read with RD_LAT=2: if_req=1, if_addr=5, RAM word 5=0x8C220004, request in cycle 0 -> ram_en=1 in cycle 1 with ram_addr=5, ram_we=0; if_ready=1 in cycle 4 with if_rdata=0x8C220004; stall_if=1 in cycles 0-3.
- Store: mem_req=1, mem_we=1, mem_addr=3, mem_wdata=0xDEADBEEF -> ram_en=ram_we=1 in cycle 1 with ram_addr=3, ram_wdata=0xDEADBEEF; mem_ready in cycle 2; mem_rdata unchanged.
- Simultaneous if_req and mem_req (load, addr 7) -> MEM is served first; IF gets ram_en in the ISSUE cycle after MEM's RESP; IF is never re-granted in a RESP cycle.
- Starvation with STARVE_MAX=3: if_req held while mem_req is held continuously for 5 loads -> grant order MEM, MEM, MEM, IF, MEM, MEM; starve counter reads 0 after the IF grant.
- Reset mid-read: assert Resetn during WAIT -> all outputs are 0 immediately, with no if_ready afterwards; after release, a fresh request completes with normal latency.
- RD_LAT=1 and RD_LAT=4 builds -> read ready arrives in cycle 3 and cycle 6 respectively; exactly one ram_en per transaction.
